// File: rtl/io_led_pwm.sv
//------------------------------------------------------------------------------
// io_led_pwm : N-channel RGB PWM LED controller on the dma_io register bus.
// Optional blink feature enabled by defining IO_LED_PWM_BLINK_EN.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module io_led_pwm #(
   parameter int          NCH       = 4,
   parameter int          PWIDTH    = 8,
   parameter int          PRE_DIV   = 64,
   parameter logic [13:0] BASE_ADR  = 14'h3E00,
   parameter int          BLINK_PER = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dma_io_we,
   input  logic [13:0]      dma_io_wadr,
   input  logic [31:0]      dma_io_wdata,
   input  logic [13:0]      dma_io_radr,
   input  logic [31:0]      dma_io_rdata_in,
   output logic [31:0]      dma_io_rdata,
   output logic [3*NCH-1:0] rgb_led
);

   localparam int               PRE_W    = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
   localparam logic [13:0]      STAT_OFF = 14'(NCH + 1);

   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [PWIDTH-1:0] pcnt_q, pcnt_d;
   logic [NCH-1:0]    en_q, en_d;
   logic [PWIDTH-1:0] shadow_q [NCH][3];
   logic [PWIDTH-1:0] shadow_d [NCH][3];
   logic [PWIDTH-1:0] active_q [NCH][3];
   logic [PWIDTH-1:0] active_d [NCH][3];
   logic [3*NCH-1:0]  led_q, led_d;

   logic [13:0]       wr_off;
   logic [13:0]       rd_off;
   logic              ctrl_wr;
   logic              clr;
   logic              tick;
   logic              wrap;
   logic [NCH-1:0]    blink_en;
   logic              phase;
   logic              unused_wdata;

   assign wr_off  = dma_io_wadr - BASE_ADR;
   assign rd_off  = dma_io_radr - BASE_ADR;
   assign ctrl_wr = dma_io_we && (wr_off == 14'd0);
   assign clr     = ctrl_wr && dma_io_wdata[16];
   assign tick    = (pre_q == PRE_LAST);
   assign wrap    = tick && (&pcnt_q);

   assign unused_wdata = &{1'b0, dma_io_wdata};

`ifdef IO_LED_PWM_BLINK_EN
   localparam int                BCNT_W    = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_PER - 1);

   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [NCH-1:0]    blink_en_q, blink_en_d;
   logic              phase_q, phase_d;

   // Blink counter advances once per PWM period; phase toggles after BLINK_PER periods.
   always_comb begin
      bcnt_d     = bcnt_q;
      phase_d    = phase_q;
      blink_en_d = blink_en_q;
      if (ctrl_wr) begin
         blink_en_d = dma_io_wdata[8 +: NCH];
      end
      if (clr) begin
         bcnt_d  = '0;
         phase_d = 1'b0;
      end else if (wrap) begin
         if (bcnt_q == BCNT_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_q     <= '0;
         phase_q    <= 1'b0;
         blink_en_q <= '0;
      end else begin
         bcnt_q     <= bcnt_d;
         phase_q    <= phase_d;
         blink_en_q <= blink_en_d;
      end
   end

   assign blink_en = blink_en_q;
   assign phase    = phase_q;
`else
   logic unused_blink_per;

   assign unused_blink_per = (BLINK_PER == 0);
   assign blink_en         = '0;
   assign phase            = 1'b0;
`endif

   always_comb begin
      pre_d    = pre_q;
      pcnt_d   = pcnt_q;
      en_d     = en_q;
      shadow_d = shadow_q;
      active_d = active_q;
      led_d    = '0;

      if (ctrl_wr) begin
         en_d = dma_io_wdata[NCH-1:0];
      end
      for (int n = 0; n < NCH; n++) begin
         if (dma_io_we && (wr_off == 14'(n + 1))) begin
            for (int c = 0; c < 3; c++) begin
               shadow_d[n][c] = dma_io_wdata[8*c +: PWIDTH];
            end
         end
      end

      // shadow_d already holds a same-cycle DUTY write, giving write-through at wrap.
      if (clr) begin
         pre_d    = '0;
         pcnt_d   = '0;
         active_d = shadow_d;
      end else begin
         if (tick) begin
            pre_d  = '0;
            pcnt_d = pcnt_q + PWIDTH'(1);
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
         if (wrap) begin
            active_d = shadow_d;
         end
      end

      for (int n = 0; n < NCH; n++) begin
         for (int c = 0; c < 3; c++) begin
            led_d[3*n + c] = en_q[n] && !(blink_en[n] && phase) &&
                             ((&active_q[n][c]) || (pcnt_q < active_q[n][c]));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         pcnt_q <= '0;
         en_q   <= '0;
         led_q  <= '0;
         for (int n = 0; n < NCH; n++) begin
            for (int c = 0; c < 3; c++) begin
               shadow_q[n][c] <= '0;
               active_q[n][c] <= '0;
            end
         end
      end else begin
         pre_q    <= pre_d;
         pcnt_q   <= pcnt_d;
         en_q     <= en_d;
         led_q    <= led_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign rgb_led = led_q;

   // Zero-latency read mux; addresses outside the map pass the upstream chain through.
   always_comb begin
      dma_io_rdata = dma_io_rdata_in;
      if (rd_off == 14'd0) begin
         dma_io_rdata            = '0;
         dma_io_rdata[NCH-1:0]   = en_q;
         dma_io_rdata[8 +: NCH]  = blink_en;
      end else if (rd_off == STAT_OFF) begin
         dma_io_rdata               = '0;
         dma_io_rdata[PWIDTH-1:0]   = pcnt_q;
         dma_io_rdata[8]            = phase;
      end else begin
         for (int n = 0; n < NCH; n++) begin
            if (rd_off == 14'(n + 1)) begin
               dma_io_rdata = '0;
               for (int c = 0; c < 3; c++) begin
                  dma_io_rdata[8*c +: PWIDTH] = shadow_q[n][c];
               end
            end
         end
      end
   end

endmodule

`default_nettype wire
